// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states and the default byte width.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request strictly after last_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               valid_o
);

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_l;
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    idx_l   = '0;
    // Walk farthest offset first so the nearest requester after last_i overrides.
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = int'(last_i) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_l = IDX_W'(idx);
      if (req_i[idx_l]) begin
        gnt_o        = '0;
        gnt_o[idx_l] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte producers; the grant is held
// until the transmitter's busy flag reports the frame complete (or the strobe times out).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = UART_DATA_W,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          uart_wr_o,
  output logic [DATA_WIDTH-1:0]         uart_dat_o,
  input  logic                          uart_busy_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  state_e                  state_q;
  logic [IDX_W-1:0]        last_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    wr_q;
  logic                    timeout_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [NUM_REQ-1:0]      grant_q;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic                    pick_vld;
  logic                    accept;
  logic [IDX_W-1:0]        win_idx;
  logic [DATA_WIDTH-1:0]   win_byte;
  logic [DATA_WIDTH-1:0]   req_byte [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_vld)
  );

  // Reset overrides a same-cycle request so no byte is handed over during reset.
  assign accept      = (state_q == IDLE) && !uart_busy_i && !sys_rst_i && pick_vld;
  assign req_ready_o = accept ? pick_gnt : '0;

  always_comb begin
    win_idx  = '0;
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        win_idx  = IDX_W'(i);
        win_byte = req_byte[i];
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q   <= IDLE;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      timeout_q <= 1'b0;
      dat_q     <= '0;
      grant_q   <= '0;
    end else begin
      wr_q      <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dat_q   <= win_byte;
            grant_q <= pick_gnt;
            last_q  <= win_idx;
            wr_q    <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q >= CNT_LAST) begin
            timeout_q <= 1'b1;
            grant_q   <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!uart_busy_i) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_wr_o  = wr_q;
  assign uart_dat_o = dat_q;
  assign grant_o    = grant_q;
  assign timeout_o  = timeout_q;

endmodule
